// File: rtl/latch_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter_if
// Description : Bundle of requester-side and latch-bank-side signals of the
//               latch bank arbiter.
//               slave  : arbiter view (consumes req/req_d, drives the rest)
//               master : requester/environment view
//   req     N        per-requester request level
//   req_d   N*WIDTH  requester data, slice i = req_d[i*WIDTH +: WIDTH]
//   gnt     N        one-hot grant for the whole transaction
//   done    N        one-cycle completion pulse
//   busy    1        arbiter not idle
//   lat_en  1        latch bank enable
//   lat_d   WIDTH    latch bank data
//   lat_rst 1        latch bank reset, active low
// Revision    : 1.0 - initial release
// ============================================================================
interface latch_bank_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_d;
  logic [N-1:0]       gnt;
  logic [N-1:0]       done;
  logic               busy;
  logic               lat_en;
  logic [WIDTH-1:0]   lat_d;
  logic               lat_rst;

  modport slave (
    input  req, req_d,
    output gnt, done, busy, lat_en, lat_d, lat_rst
  );

  modport master (
    output req, req_d,
    input  gnt, done, busy, lat_en, lat_d, lat_rst
  );
endinterface
`default_nettype wire

// File: rtl/latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter
// Description : Round-robin arbiter/sequencer sharing one transparent latch
//               bank among N requesters. The winner's data is captured and
//               presented on lat_d, lat_en opens for EN_CYCLES, lat_d is held
//               for HOLD_CYCLES, then done pulses to the winner.
//   clk   in  rising-edge clock
//   rst   in  synchronous reset, active low
//   bus   slave modport of latch_bank_arbiter_if (req, req_d in;
//         gnt, done, busy, lat_en, lat_d, lat_rst out)
// Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_arbiter #(
  parameter int N           = 4,
  parameter int WIDTH       = 8,
  parameter int EN_CYCLES   = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  wire                  clk,
  input  wire                  rst,
  latch_bank_arbiter_if.slave  bus
);

  localparam int c_PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [c_PW-1:0]    r_ptr, w_ptr_nxt;
  logic [c_PW-1:0]    r_win, w_win_nxt;
  logic [N-1:0]       r_gnt, w_gnt_nxt;
  logic [N-1:0]       r_done, w_done_nxt;
  logic               r_busy;
  logic               r_lat_en, w_lat_en_nxt;
  logic [WIDTH-1:0]   r_lat_d, w_lat_d_nxt;
  logic               r_lat_rst;

  // Round-robin pick: first set req bit at or above the pointer, wrapping.
  logic               w_found;
  logic [c_PW-1:0]    w_winner;
  logic [c_PW:0]      w_sum;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (c_PW+1)'(i);
      if (w_sum >= (c_PW+1)'(N)) begin
        w_sum = w_sum - (c_PW+1)'(N);
      end
      if (!w_found && bus.req[w_sum[c_PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_PW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = r_done;
    w_lat_en_nxt = r_lat_en;
    w_lat_d_nxt  = r_lat_d;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt           = SETUP;
          w_win_nxt             = w_winner;
          w_gnt_nxt             = '0;
          w_gnt_nxt[w_winner]   = 1'b1;
          w_lat_d_nxt           = bus.req_d[w_winner*WIDTH +: WIDTH];
          w_ptr_nxt             = (w_winner == c_PW'(N-1)) ? '0 : w_winner + 1'b1;
        end
      end
      SETUP: begin
        w_state_nxt  = OPEN;
        w_lat_en_nxt = 1'b1;
        w_cnt_nxt    = 4'(EN_CYCLES);
      end
      OPEN: begin
        // Counter reloads on entry and counts down to 1 before advancing.
        if (r_cnt <= 4'd1) begin
          w_state_nxt  = HOLD;
          w_lat_en_nxt = 1'b0;
          w_cnt_nxt    = 4'(HOLD_CYCLES);
        end else begin
          w_cnt_nxt    = r_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt        = DONE;
          w_done_nxt         = '0;
          w_done_nxt[r_win]  = 1'b1;
        end else begin
          w_cnt_nxt          = r_cnt - 4'd1;
        end
      end
      DONE: begin
        // lat_d intentionally keeps its last value.
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_done_nxt   = '0;
        w_lat_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_win     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_lat_en  <= 1'b0;
      r_lat_d   <= '0;
      r_lat_rst <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_win     <= w_win_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_lat_en  <= w_lat_en_nxt;
      r_lat_d   <= w_lat_d_nxt;
      // Delayed copy of rst: latch bank stays cleared one cycle past release.
      r_lat_rst <= 1'b1;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.lat_en  = r_lat_en;
  assign bus.lat_d   = r_lat_d;
  assign bus.lat_rst = r_lat_rst;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_bank_arbiter
// Description : Self-checking bench for latch_bank_arbiter (N=4, WIDTH=8,
//               EN_CYCLES=2, HOLD_CYCLES=1). Expected grant/data pairs are
//               queued when a request is driven and compared on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_arbiter;

  localparam int c_N = 4;
  localparam int c_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  latch_bank_arbiter_if #(.N(c_N), .WIDTH(c_W)) bus ();

  latch_bank_arbiter #(
    .N(c_N), .WIDTH(c_W), .EN_CYCLES(2), .HOLD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [c_N-1:0] g;
    logic [c_W-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    bus.req = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    sb.delete();
  endtask

  task automatic set_slice(input int i, input logic [c_W-1:0] v);
    bus.req_d[i*c_W +: c_W] = v;
  endtask

  // Advance until done is seen or the budget runs out; reports cycles used
  // and the largest number of gnt bits seen set at once.
  task automatic wait_done(input int budget, output logic to,
                           output int cycles, output int maxpop);
    to = 1'b1; cycles = 0; maxpop = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if ($countones(bus.gnt) > maxpop) maxpop = $countones(bus.gnt);
      if (bus.done != '0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic to; int cyc; int mp;
    rst     = 1'b0;
    bus.req = 4'hF;
    for (int i = 0; i < c_N; i++) set_slice(i, 8'h10 + 8'(i));
    repeat (3) tick();
    total++; if (bus.gnt !== 4'h0) $display("FAIL reset_gnt: got %h want 0", bus.gnt); else passed++;
    total++; if (bus.lat_en !== 1'b0) $display("FAIL reset_lat_en: got %b want 0", bus.lat_en); else passed++;
    total++; if (bus.lat_d !== 8'h00) $display("FAIL reset_lat_d: got %h want 00", bus.lat_d); else passed++;
    total++; if (bus.lat_rst !== 1'b0) $display("FAIL reset_lat_rst: got %b want 0", bus.lat_rst); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    rst = 1'b1;
    sb.push_back('{g: 4'b0001, d: 8'h10});
    total++; if (bus.lat_rst !== 1'b0) $display("FAIL release_lat_rst_low: got %b want 0", bus.lat_rst); else passed++;
    tick();
    total++; if (bus.lat_rst !== 1'b1) $display("FAIL release_lat_rst_high: got %b want 1", bus.lat_rst); else passed++;
    total++; if (bus.gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); else passed++;
    bus.req = '0;
    wait_done(20, to, cyc, mp);
    e = sb.pop_front();
    total++;
    if (to) $display("FAIL reset_done_timeout: got none want %b", e.g);
    else if (bus.done !== e.g || bus.lat_d !== e.d)
      $display("FAIL reset_done: got done=%b lat_d=%h want done=%b lat_d=%h", bus.done, bus.lat_d, e.g, e.d);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    set_slice(2, 8'hA5);
    bus.req = 4'b0100;
    sb.push_back('{g: 4'b0100, d: 8'hA5});
    tick();
    total++; if (bus.gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", bus.gnt); else passed++;
    total++; if (bus.lat_d !== 8'hA5) $display("FAIL single_lat_d: got %h want a5", bus.lat_d); else passed++;
    total++; if (bus.lat_en !== 1'b0) $display("FAIL single_setup_en: got %b want 0", bus.lat_en); else passed++;
    tick();
    total++; if (bus.lat_en !== 1'b1) $display("FAIL single_en_c2: got %b want 1", bus.lat_en); else passed++;
    tick();
    total++; if (bus.lat_en !== 1'b1) $display("FAIL single_en_c3: got %b want 1", bus.lat_en); else passed++;
    tick();
    total++; if (bus.lat_en !== 1'b0 || bus.done !== 4'h0)
      $display("FAIL single_hold_c4: got en=%b done=%b want en=0 done=0000", bus.lat_en, bus.done); else passed++;
    tick();
    e = sb.pop_front();
    total++; if (bus.done !== e.g) $display("FAIL single_done_c5: got %b want %b", bus.done, e.g); else passed++;
    total++; if (bus.gnt !== e.g) $display("FAIL single_gnt_c5: got %b want %b", bus.gnt, e.g); else passed++;
    bus.req = '0;
    tick();
    total++; if (bus.done !== 4'h0 || bus.gnt !== 4'h0)
      $display("FAIL single_idle: got done=%b gnt=%b want 0000/0000", bus.done, bus.gnt); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.lat_d !== 8'hA5) $display("FAIL single_idle_lat_d: got %h want a5", bus.lat_d); else passed++;
  endtask

  task automatic test_fairness();
    logic to; int cyc; int mp;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < c_N; i++) set_slice(i, 8'h20 + 8'(i));
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_t x;
      x.g = 4'b0001 << order[k];
      x.d = 8'h20 + 8'(order[k]);
      sb.push_back(x);
    end
    for (int k = 0; k < 5; k++) begin
      wait_done(20, to, cyc, mp);
      e = sb.pop_front();
      total++;
      if (to) begin
        $display("FAIL fair_timeout_%0d: got none want %b", k, e.g);
        break;
      end
      if (bus.done !== e.g || bus.gnt !== e.g || bus.lat_d !== e.d)
        $display("FAIL fair_grant_%0d: got done=%b gnt=%b lat_d=%h want %b/%b/%h",
                 k, bus.done, bus.gnt, bus.lat_d, e.g, e.g, e.d);
      else passed++;
      total++; if (cyc != ((k == 0) ? 5 : 6))
        $display("FAIL fair_period_%0d: got %0d want %0d", k, cyc, (k == 0) ? 5 : 6); else passed++;
      total++; if (mp > 1) $display("FAIL fair_onehot_%0d: got %0d bits want <=1", k, mp); else passed++;
    end
    bus.req = '0;
  endtask

  task automatic test_abandon();
    logic to; int cyc; int mp;
    do_reset();
    set_slice(1, 8'h5A);
    bus.req = 4'b0010;
    sb.push_back('{g: 4'b0010, d: 8'h5A});
    tick();
    tick();
    total++; if (bus.lat_en !== 1'b1) $display("FAIL abandon_en_c2: got %b want 1", bus.lat_en); else passed++;
    bus.req = '0;
    set_slice(1, 8'h00);
    tick();
    total++; if (bus.lat_en !== 1'b1 || bus.lat_d !== 8'h5A)
      $display("FAIL abandon_c3: got en=%b lat_d=%h want 1/5a", bus.lat_en, bus.lat_d); else passed++;
    tick();
    total++; if (bus.lat_en !== 1'b0) $display("FAIL abandon_c4: got %b want 0", bus.lat_en); else passed++;
    wait_done(10, to, cyc, mp);
    e = sb.pop_front();
    total++;
    if (to || cyc != 1 || bus.done !== e.g || bus.lat_d !== e.d)
      $display("FAIL abandon_done: got done=%b lat_d=%h cyc=%0d want %b/%h/1", bus.done, bus.lat_d, cyc, e.g, e.d);
    else passed++;
  endtask

  task automatic test_reset_mid_open();
    logic to; int cyc; int mp;
    do_reset();
    set_slice(2, 8'h77);
    set_slice(3, 8'h88);
    bus.req = 4'b0100;
    tick();
    tick();
    total++; if (bus.lat_en !== 1'b1) $display("FAIL abort_pre_en: got %b want 1", bus.lat_en); else passed++;
    rst = 1'b0;
    tick();
    total++; if (bus.lat_en !== 1'b0 || bus.gnt !== 4'h0 || bus.done !== 4'h0)
      $display("FAIL abort_outputs: got en=%b gnt=%b done=%b want 0/0000/0000", bus.lat_en, bus.gnt, bus.done);
    else passed++;
    total++; if (bus.lat_rst !== 1'b0) $display("FAIL abort_lat_rst: got %b want 0", bus.lat_rst); else passed++;
    rst = 1'b1;
    bus.req = 4'b1100;
    sb.push_back('{g: 4'b0100, d: 8'h77});
    wait_done(20, to, cyc, mp);
    e = sb.pop_front();
    total++;
    if (to || cyc != 5 || bus.done !== e.g || bus.lat_d !== e.d)
      $display("FAIL abort_next_grant: got done=%b lat_d=%h cyc=%0d want %b/%h/5", bus.done, bus.lat_d, cyc, e.g, e.d);
    else passed++;
    bus.req = '0;
  endtask

  task automatic test_data_isolation();
    logic to; int cyc; int mp;
    logic bad;
    do_reset();
    set_slice(0, 8'h3C);
    bus.req = 4'b0001;
    sb.push_back('{g: 4'b0001, d: 8'h3C});
    tick();
    total++; if (bus.lat_d !== 8'h3C) $display("FAIL iso_setup: got %h want 3c", bus.lat_d); else passed++;
    set_slice(0, 8'hFF);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.lat_d !== 8'h3C) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL iso_stable: got changed lat_d=%h want 3c", bus.lat_d); else passed++;
    wait_done(10, to, cyc, mp);
    e = sb.pop_front();
    total++;
    if (to || bus.done !== e.g || bus.lat_d !== e.d)
      $display("FAIL iso_done: got done=%b lat_d=%h want %b/%h", bus.done, bus.lat_d, e.g, e.d);
    else passed++;
    bus.req = '0;
    tick();
    total++; if (bus.lat_d !== 8'h3C || bus.gnt !== 4'h0)
      $display("FAIL iso_idle: got lat_d=%h gnt=%b want 3c/0000", bus.lat_d, bus.gnt); else passed++;
  endtask

  initial begin
    bus.req   = '0;
    bus.req_d = '0;
    test_reset();
    test_single();
    test_fairness();
    test_abandon();
    test_reset_mid_open();
    test_data_isolation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
